// File: rtl/imem_program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Holds the loader state encoding, stream geometry and header limits.
package imem_program_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int IMEM_DEPTH     = 32;
    localparam int MIN_WORDS      = 1;
    localparam int MAX_WORDS      = 32;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR      = 3'd1,
        ST_ASSEMBLE = 3'd2,
        ST_WRITE    = 3'd3,
        ST_DONE     = 3'd4,
        ST_ERR      = 3'd5
    } state_e;

    // A header is usable only if it names between MIN_WORDS and MAX_WORDS words.
    function automatic logic header_ok(input logic [7:0] hdr);
        return (hdr >= 8'(MIN_WORDS)) && (hdr <= 8'(MAX_WORDS));
    endfunction

endpackage

// File: rtl/imem_program_loader_word_packer.sv
// Big-endian byte-to-word shift register with a 2-bit byte index.
// word_full flags the shift that completes a word; word_next is that word.
module word_packer
    import imem_program_loader_pkg::*;
#(
    parameter int BYTE_W = 8,
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word_next,
    output logic              word_full
);

    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_d;
    logic [1:0]        byte_idx_q;
    logic [1:0]        byte_idx_d;

    // Next-state for the shift register and byte index.
    always_comb begin
        word_next  = {word_q[WORD_W-BYTE_W-1:0], byte_in};
        word_full  = shift_en && (byte_idx_q == 2'(BYTES_PER_WORD - 1));
        word_d     = word_q;
        byte_idx_d = byte_idx_q;
        if (clear) begin
            word_d     = '0;
            byte_idx_d = 2'd0;
        end else if (shift_en) begin
            word_d     = word_next;
            byte_idx_d = byte_idx_q + 2'd1;
        end else begin
            word_d     = word_q;
            byte_idx_d = byte_idx_q;
        end
    end

    // Register the shift state; reset discards any partial word.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q     <= '0;
            byte_idx_q <= 2'd0;
        end else begin
            word_q     <= word_d;
            byte_idx_q <= byte_idx_d;
        end
    end

endmodule

// File: rtl/imem_program_loader.sv
// Loads a header-prefixed byte stream into instruction memory word by word,
// holding the CPU datapath in reset until the whole program has been written.
module imem_program_loader
    import imem_program_loader_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int WORD_W = 32,
    parameter int BYTE_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_byte,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   word_count
);

    state_e            state_q,      state_d;
    logic [ADDR_W:0]   n_words_q,    n_words_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              in_ready_q,   in_ready_d;
    logic              imem_we_q,    imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q,  imem_addr_d;
    logic [WORD_W-1:0] imem_wdata_q, imem_wdata_d;
    logic              cpu_reset_q,  cpu_reset_d;
    logic              load_busy_q,  load_busy_d;
    logic              load_done_q,  load_done_d;
    logic              load_err_q,   load_err_d;

    logic              accept;
    logic              packer_clear;
    logic              packer_shift;
    logic [WORD_W-1:0] packer_word;
    logic              packer_full;
    logic [ADDR_W:0]   count_inc;

    assign accept       = in_valid && in_ready_q;
    assign packer_clear = (state_q == ST_HDR) && accept;
    assign packer_shift = (state_q == ST_ASSEMBLE) && accept;
    assign count_inc    = word_count_q + {{ADDR_W{1'b0}}, 1'b1};

    word_packer #(
        .BYTE_W (BYTE_W),
        .WORD_W (WORD_W)
    ) u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (packer_clear),
        .shift_en  (packer_shift),
        .byte_in   (in_byte),
        .word_next (packer_word),
        .word_full (packer_full)
    );

    // State transitions plus next values of every registered output.
    always_comb begin
        state_d      = state_q;
        n_words_d    = n_words_q;
        word_count_d = word_count_q;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d = ST_HDR;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HDR: begin
                if (accept) begin
                    if (header_ok(in_byte)) begin
                        n_words_d    = in_byte[ADDR_W:0];
                        word_count_d = '0;
                        state_d      = ST_ASSEMBLE;
                    end else begin
                        state_d = ST_ERR;
                    end
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_ASSEMBLE: begin
                // Address and data are captured as the 4th byte lands so they
                // are stable for the whole WRITE cycle.
                if (packer_full) begin
                    imem_addr_d  = word_count_q[ADDR_W-1:0];
                    imem_wdata_d = packer_word;
                    state_d      = ST_WRITE;
                end else begin
                    state_d = ST_ASSEMBLE;
                end
            end
            ST_WRITE: begin
                word_count_d = count_inc;
                if (count_inc == n_words_q) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_ASSEMBLE;
                end
            end
            ST_DONE, ST_ERR: begin
                if (load_start) begin
                    state_d = ST_HDR;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        in_ready_d  = (state_d == ST_HDR) || (state_d == ST_ASSEMBLE);
        imem_we_d   = (state_d == ST_WRITE);
        cpu_reset_d = (state_d != ST_DONE);
        load_busy_d = (state_d == ST_HDR) || (state_d == ST_ASSEMBLE) || (state_d == ST_WRITE);
        load_done_d = (state_d == ST_DONE);
        load_err_d  = (state_d == ST_ERR);
    end

    // Single register stage for the FSM and all of its outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            n_words_q    <= '0;
            word_count_q <= '0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            load_busy_q  <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            n_words_q    <= n_words_d;
            word_count_q <= word_count_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            load_busy_q  <= load_busy_d;
            load_done_q  <= load_done_d;
            load_err_q   <= load_err_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign load_busy  = load_busy_q;
    assign load_done  = load_done_q;
    assign load_err   = load_err_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: a per-cycle vector table for the
// basic load, then hand-written sequences for stalls, errors, depth, reset and reload.
module tb_imem_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        load_start;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        imem_we;
    logic [4:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        load_busy;
    logic        load_done;
    logic        load_err;
    logic [5:0]  word_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int t0       = 0;

    logic [4:0]  log_addr[$];
    logic [31:0] log_data[$];

    typedef struct {
        logic        ls;
        logic        v;
        logic [7:0]  b;
        logic        rdy;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wd;
        logic        cr;
        logic        busy;
        logic        done;
        logic        err;
        logic [5:0]  wc;
    } vec_t;

    vec_t tbl[12];

    imem_program_loader dut (
        .clk        (clk),
        .reset      (reset),
        .load_start (load_start),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .load_busy  (load_busy),
        .load_done  (load_done),
        .load_err   (load_err),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: log every write strobe; the stream must be blocked while writing.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            log_addr.push_back(imem_addr);
            log_data.push_back(imem_wdata);
            chk("ready_low_in_write", {31'd0, in_ready}, 32'd0);
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"},   {31'd0, in_ready},   32'd0);
        chk({tag, "_imem_we"},    {31'd0, imem_we},    32'd0);
        chk({tag, "_imem_addr"},  {27'd0, imem_addr},  32'd0);
        chk({tag, "_imem_wdata"}, imem_wdata,          32'd0);
        chk({tag, "_cpu_reset"},  {31'd0, cpu_reset},  32'd1);
        chk({tag, "_load_busy"},  {31'd0, load_busy},  32'd0);
        chk({tag, "_load_done"},  {31'd0, load_done},  32'd0);
        chk({tag, "_load_err"},   {31'd0, load_err},   32'd0);
        chk({tag, "_word_count"}, {26'd0, word_count}, 32'd0);
    endtask

    task automatic start_load();
        @(negedge clk);
        load_start = 1'b1;
        in_valid   = 1'b0;
        @(posedge clk);
        #1;
        t0         = cyc;
        load_start = 1'b0;
    endtask

    // Present one byte, optionally after an idle cycle, and hold it until accepted.
    task automatic send_byte(input logic [7:0] b, input bit stall);
        bit ok;
        ok = 1'b0;
        if (stall) begin
            @(negedge clk);
            in_valid = 1'b0;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_byte  = b;
        for (int k = 0; k < 20; k++) begin
            if (in_ready) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                ok = 1'b1;
                break;
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) in_valid = 1'b0;
        chk("byte_accepted", {31'd0, ok}, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit stall);
        send_byte(w[31:24], stall);
        send_byte(w[23:16], stall);
        send_byte(w[15:8],  stall);
        send_byte(w[7:0],   stall);
    endtask

    task automatic wait_done(input int max_cycles);
        for (int k = 0; k < max_cycles; k++) begin
            if (load_done) break;
            @(posedge clk);
            #1;
        end
        chk("done_reached", {31'd0, load_done}, 32'd1);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[1]  = '{1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 5'd0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[2]  = '{1'b0, 1'b1, 8'h12, 1'b1, 1'b0, 5'd0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[3]  = '{1'b0, 1'b1, 8'h34, 1'b1, 1'b0, 5'd0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[4]  = '{1'b0, 1'b1, 8'h56, 1'b1, 1'b0, 5'd0, 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[5]  = '{1'b0, 1'b1, 8'h78, 1'b0, 1'b1, 5'd0, 32'h12345678, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0};
        tbl[6]  = '{1'b0, 1'b1, 8'h9A, 1'b1, 1'b0, 5'd0, 32'h12345678, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1};
        tbl[7]  = '{1'b0, 1'b1, 8'h9A, 1'b1, 1'b0, 5'd0, 32'h12345678, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1};
        tbl[8]  = '{1'b0, 1'b1, 8'hBC, 1'b1, 1'b0, 5'd0, 32'h12345678, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1};
        tbl[9]  = '{1'b0, 1'b1, 8'hDE, 1'b1, 1'b0, 5'd0, 32'h12345678, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1};
        tbl[10] = '{1'b0, 1'b1, 8'hF0, 1'b0, 1'b1, 5'd1, 32'h9ABCDEF0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd1};
        tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b1, 1'b0, 6'd2};

        reset      = 1'b1;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_byte    = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Basic 2-word load, one vector per clock.
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            load_start = tbl[i].ls;
            in_valid   = tbl[i].v;
            in_byte    = tbl[i].b;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_in_ready", i),   {31'd0, in_ready},   {31'd0, tbl[i].rdy});
            chk($sformatf("v%0d_imem_we", i),    {31'd0, imem_we},    {31'd0, tbl[i].we});
            chk($sformatf("v%0d_imem_addr", i),  {27'd0, imem_addr},  {27'd0, tbl[i].addr});
            chk($sformatf("v%0d_imem_wdata", i), imem_wdata,          tbl[i].wd);
            chk($sformatf("v%0d_cpu_reset", i),  {31'd0, cpu_reset},  {31'd0, tbl[i].cr});
            chk($sformatf("v%0d_load_busy", i),  {31'd0, load_busy},  {31'd0, tbl[i].busy});
            chk($sformatf("v%0d_load_done", i),  {31'd0, load_done},  {31'd0, tbl[i].done});
            chk($sformatf("v%0d_load_err", i),   {31'd0, load_err},   {31'd0, tbl[i].err});
            chk($sformatf("v%0d_word_count", i), {26'd0, word_count}, {26'd0, tbl[i].wc});
        end
        load_start = 1'b0;
        in_valid   = 1'b0;
        chk("basic_nwrites", log_addr.size(), 32'd2);
        if (log_addr.size() == 2) begin
            chk("basic_w0_addr", {27'd0, log_addr[0]}, 32'd0);
            chk("basic_w0_data", log_data[0], 32'h12345678);
            chk("basic_w1_addr", {27'd0, log_addr[1]}, 32'd1);
            chk("basic_w1_data", log_data[1], 32'h9ABCDEF0);
        end

        // Same stream with an idle cycle before every byte.
        log_addr.delete();
        log_data.delete();
        start_load();
        send_byte(8'h02, 1'b1);
        send_word(32'h12345678, 1'b1);
        send_word(32'h9ABCDEF0, 1'b1);
        wait_done(20);
        chk("stall_word_count", {26'd0, word_count}, 32'd2);
        chk("stall_nwrites", log_addr.size(), 32'd2);
        if (log_addr.size() == 2) begin
            chk("stall_w0_addr", {27'd0, log_addr[0]}, 32'd0);
            chk("stall_w0_data", log_data[0], 32'h12345678);
            chk("stall_w1_addr", {27'd0, log_addr[1]}, 32'd1);
            chk("stall_w1_data", log_data[1], 32'h9ABCDEF0);
        end

        // Bad headers 0x00 and 0x21, then recovery with a valid 1-word load.
        log_addr.delete();
        log_data.delete();
        start_load();
        send_byte(8'h00, 1'b0);
        chk("hdr00_load_err", {31'd0, load_err}, 32'd1);
        chk("hdr00_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("hdr00_in_ready", {31'd0, in_ready}, 32'd0);
        start_load();
        send_byte(8'h21, 1'b0);
        chk("hdr21_load_err", {31'd0, load_err}, 32'd1);
        chk("hdr21_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("hdr_err_nwrites", log_addr.size(), 32'd0);
        start_load();
        chk("err_restart_err_clear", {31'd0, load_err}, 32'd0);
        send_byte(8'h01, 1'b0);
        send_word(32'hCAFEF00D, 1'b0);
        wait_done(10);
        chk("recover_nwrites", log_addr.size(), 32'd1);
        if (log_addr.size() == 1) chk("recover_data", log_data[0], 32'hCAFEF00D);

        // Full depth: 32 words, latency from HDR entry to DONE.
        log_addr.delete();
        log_data.delete();
        start_load();
        send_byte(8'h20, 1'b0);
        for (int k = 0; k < 32; k++) send_word(32'hA5000000 + k, 1'b0);
        wait_done(10);
        chk("full_latency", cyc - t0, 32'd161);
        chk("full_word_count", {26'd0, word_count}, 32'd32);
        chk("full_nwrites", log_addr.size(), 32'd32);
        if (log_addr.size() == 32) begin
            for (int k = 0; k < 32; k++) begin
                chk($sformatf("full_addr%0d", k), {27'd0, log_addr[k]}, k);
                chk($sformatf("full_data%0d", k), log_data[k], 32'hA5000000 + k);
            end
        end

        // Reset in the middle of the second word of a 3-word load.
        log_addr.delete();
        log_data.delete();
        start_load();
        send_byte(8'h03, 1'b0);
        send_word(32'h11223344, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("midreset_idle_ready", {31'd0, in_ready}, 32'd0);
        chk("midreset_nwrites", log_addr.size(), 32'd1);
        if (log_addr.size() == 1) begin
            chk("midreset_addr", {27'd0, log_addr[0]}, 32'd0);
            chk("midreset_data", log_data[0], 32'h11223344);
        end

        // Reload from DONE: CPU goes back into reset immediately.
        log_addr.delete();
        log_data.delete();
        start_load();
        send_byte(8'h01, 1'b0);
        send_word(32'hDEADBEEF, 1'b0);
        wait_done(10);
        chk("reload_first_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        start_load();
        chk("reload_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("reload_busy", {31'd0, load_busy}, 32'd1);
        chk("reload_done_clear", {31'd0, load_done}, 32'd0);
        send_byte(8'h01, 1'b0);
        send_word(32'h0BADC0DE, 1'b0);
        wait_done(10);
        chk("reload_nwrites", log_addr.size(), 32'd2);
        if (log_addr.size() == 2) begin
            chk("reload_addr", {27'd0, log_addr[1]}, 32'd0);
            chk("reload_data", log_data[1], 32'h0BADC0DE);
        end
        chk("reload_word_count", {26'd0, word_count}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
